// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one fp_divider between two lanes, with in-order owner tracking.
// Define FP_DIV_ARB_STATS_EN to add the saturating grant/stall statistics counters.
module fp_div_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [63:0]              req_op_a,
    input  logic [63:0]              req_op_b,
    input  logic [1:0]               req_mode_fp,
    input  logic [1:0]               req_round_mode,
    output logic                     unit_start,
    output logic [31:0]              unit_op_a,
    output logic [31:0]              unit_op_b,
    output logic                     unit_mode_fp,
    output logic                     unit_round_mode,
    input  logic                     unit_ready,
    input  logic                     unit_valid,
    output logic                     unit_ready_in,
    input  logic                     unit_sign,
    input  logic [7:0]               unit_exp,
    input  logic [26:0]              unit_mant,
    input  logic [4:0]               unit_flags,
    input  logic                     unit_mode_fp_out,
    output logic [1:0]               resp_valid,
    input  logic [1:0]               resp_ready,
    output logic                     resp_sign,
    output logic [7:0]               resp_exp,
    output logic [26:0]              resp_mant,
    output logic [4:0]               resp_flags,
    output logic                     resp_mode_fp,
    output logic [$clog2(DEPTH):0]   inflight,
`ifdef FP_DIV_ARB_STATS_EN
    output logic [CNT_W-1:0]         stat_grant0,
    output logic [CNT_W-1:0]         stat_grant1,
    output logic [CNT_W-1:0]         stat_stall,
`endif
    output logic                     err_orphan
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
        $error("fp_div_arbiter: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    logic [AW:0]      count;
    logic [AW-1:0]    wp, rp;
    logic [DEPTH-1:0] ids;
    logic             last_grant, can_issue, grant, g, h, busy, pop;

    // The owner FIFO holds one lane bit per in-flight op; its head owns the next divider result.
    always_comb begin
        busy            = count != '0;
        h               = ids[rp];
        can_issue       = !rst && unit_ready && count < (AW+1)'(DEPTH);
        grant           = can_issue && |req_valid;
        g               = &req_valid ? ~last_grant : req_valid[1];
        req_ready       = grant ? (g ? 2'b10 : 2'b01) : 2'b00;
        unit_start      = grant;
        unit_op_a       = g ? req_op_a[63:32] : req_op_a[31:0];
        unit_op_b       = g ? req_op_b[63:32] : req_op_b[31:0];
        unit_mode_fp    = req_mode_fp[g];
        unit_round_mode = req_round_mode[g];
        resp_valid      = (rst || !busy) ? 2'b00 : (h ? {unit_valid, 1'b0} : {1'b0, unit_valid});
        unit_ready_in   = busy ? resp_ready[h] : 1'b1;
        pop             = busy && unit_valid && resp_ready[h];
        resp_sign       = unit_sign;
        resp_exp        = unit_exp;
        resp_mant       = unit_mant;
        resp_flags      = unit_flags;
        resp_mode_fp    = unit_mode_fp_out;
        inflight        = count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wp         <= '0;
            rp         <= '0;
            last_grant <= 1'b1;
            err_orphan <= 1'b0;
        end else begin
            if (grant) begin
                ids[wp]    <= g;
                wp         <= wp + AW'(1);
                last_grant <= g;
            end
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(grant) - (AW+1)'(pop);
            if (unit_valid && !busy) err_orphan <= 1'b1;
        end
    end

`ifdef FP_DIV_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant && !g && stat_grant0 != '1) stat_grant0 <= stat_grant0 + CNT_W'(1);
            if (grant && g && stat_grant1 != '1) stat_grant1 <= stat_grant1 + CNT_W'(1);
            if (!grant && |req_valid && stat_stall != '1) stat_stall <= stat_stall + CNT_W'(1);
        end
    end
`endif
endmodule
